vram_write_snoop: RTL and testbench
===================================

// Module: vram_write_snoop
// PURPOSE
//  Snoops 68000 bus writes aimed at the Mac SE main/alt frame buffers and replays them into VRAM.
//  It is the writer on the VRAM port: the pixel shifter owns the read slot at vidSeq==0.
//  Each captured word goes into a small FIFO, then drains as 1-2 byte writes inside the slots vidSeq 1..5.
//  It sits beside the video timing/shifter in sevga, and its VRAM outputs merge with the read strobe.
// PARAMETERS
//  FIFO_DEPTH  4       entries in capture FIFO (power of 2, >=2)
//  BUF_BYTES   'h5580  frame buffer length in bytes (512x342/8)
//  MAIN_OFS    'h5900  main buffer base = ramTop - MAIN_OFS
//  ALT_OFS     'hD900  alt buffer base  = ramTop - ALT_OFS
// PORTS
//  pixClk       in   1   25.175MHz pixel clock; all state on negedge (matches video timing)
//  reset        in   1   asynchronous, active-high reset
//  cpuAddr      in   23  CPU address A[23:1], async to pixClk
//  cpuData      in   16  CPU data bus
//  ncpuAS       in   1   address strobe, active low
//  ncpuUDS      in   1   upper data strobe (even byte), active low
//  ncpuLDS      in   1   lower data strobe (odd byte), active low
//  cpuRnW       in   1   1=read, 0=write
//  ramSize      in   3   RAM top: 0=1MB 1=2MB 2=2.5MB 3..7=4MB
//  vidSeq       in   3   hCount[3:1] from video timing; write starts legal only in 1..5
//  vramAddr     out  15  VRAM byte address during write
//  vramDataOut  out  8   byte to write
//  vramDataOE   out  1   1 = drive vramData with vramDataOut
//  nvramWE      out  1   VRAM write strobe, active low
//  nvramCE0     out  1   main-buffer chip select, active low
//  nvramCE1     out  1   alt-buffer chip select, active low
//  wrBusy       out  1   FIFO non-empty or write in progress
//  fifoOvf      out  1   sticky: a hit write was dropped because FIFO was full
// BEHAVIOUR
//  Reset (async): FIFO empty, FSM IDLE, vramAddr=0, vramDataOut=0, vramDataOE=0,
//   nvramWE=nvramCE0=nvramCE1=1, wrBusy=0, fifoOvf=0. A write in flight is abandoned; WE/CE deassert at once.
//  Sync: ncpuAS, ncpuUDS, ncpuLDS, cpuRnW each pass through a 2-flop synchroniser; cpuAddr/cpuData are sampled raw.
//  Capture: an armed flag sets while synced AS is high.
//   Capture fires when armed & AS low & RnW=0 & (UDS|LDS low); armed then clears. One capture per bus cycle.
//  Decode: A={cpuAddr,1'b0}; ramTop from ramSize.
//   Main hit: A in [ramTop-MAIN_OFS, +BUF_BYTES). Alt hit likewise with ALT_OFS.
//   Offset = A-base, 15 bits. A miss, or a read, is ignored.
//  Push: entry={sel(0=main,1=alt), offset[14:1], data16, ue, le}; ue/le = synced UDS/LDS low.
//   FIFO full on push: entry dropped, fifoOvf<=1. Push+pop in the same clock is legal while full.
//  Write FSM: IDLE -> SETUP -> STROBE -> HOLD -> (next byte ? SETUP : IDLE).
//   IDLE->SETUP only when FIFO non-empty & vidSeq in 1..5. Before each SETUP the FSM re-checks vidSeq in 1..5; if not, it waits in IDLE.
//   SETUP: vramAddr, vramDataOut, vramDataOE=1 and CEsel=0 driven. STROBE: nvramWE=0. HOLD: WE=1; CE/data held.
//   Leaving HOLD drops CE and OE.
//   Byte order: ue first (addr=offset, data[15:8]), then le (addr=offset|1, data[7:0]).
//   Pop on the HOLD of the entry's last byte.
//   Latency: 3 clocks/byte; a word write = 2 windows; the window never overlaps vidSeq 0.
//  wrBusy = !empty | state!=IDLE. No output glitches: WE/CE/OE are registered.
// TESTING
//  T1 ramSize=0, word write A=0x0FA700 data 0xA55A UDS+LDS -> CE0 writes 0x0000=0xA5, then 0x0001=0x5A, each in vidSeq 1..5.
//  T2 ramSize=3, byte write LDS only A=0x3F2701 data 0x00C3 -> single CE1 write, addr 0x0001, data 0xC3; no UDS write.
//  T3 write A=0x0FA6FE, and A=0x0FA700+0x5580, and a read at 0x0FA700 -> no VRAM activity, wrBusy stays 0.
//  T4 six back-to-back hit writes, vidSeq held at 0 -> 4 queued, fifoOvf=1; vidSeq released -> 4 entries drain in order.
//  T5 reset asserted during STROBE -> nvramWE/CE0/OE high same cycle; after release FIFO empty, wrBusy=0.
//  T6 AS held low across 10 clocks with DS low -> exactly one FIFO push.

Source files
------------

// File: rtl/vram_write_snoop.sv
// vram_write_snoop: watches 68000 writes that land in the Mac SE main or alt
// frame buffer and replays them as byte writes on the VRAM port. Captured words
// queue in a small FIFO. The write FSM drains it only in the vidSeq 1..5 slots,
// which leaves slot 0 free for the pixel shifter's read.
module vram_write_snoop #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [23:0] BUF_BYTES  = 24'h5580,
    parameter logic [23:0] MAIN_OFS   = 24'h5900,
    parameter logic [23:0] ALT_OFS    = 24'hD900
) (
    input  logic        pixClk,
    input  logic        reset,
    input  logic [22:0] cpuAddr,
    input  logic [15:0] cpuData,
    input  logic        ncpuAS,
    input  logic        ncpuUDS,
    input  logic        ncpuLDS,
    input  logic        cpuRnW,
    input  logic [2:0]  ramSize,
    input  logic [2:0]  vidSeq,
    output logic [14:0] vramAddr,
    output logic [7:0]  vramDataOut,
    output logic        vramDataOE,
    output logic        nvramWE,
    output logic        nvramCE0,
    output logic        nvramCE1,
    output logic        wrBusy,
    output logic        fifoOvf
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic        sel;
        logic [13:0] off;
        logic [15:0] data;
        logic        ue;
        logic        le;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    logic [1:0]  as_sync, uds_sync, lds_sync, rnw_sync;
    logic        as_s, uds_s, lds_s, rnw_s;
    logic        armed, capture;
    logic [23:0] byte_addr, ram_top, main_rel, alt_rel;
    logic        main_hit, alt_hit, push_req, push_ok, pop;
    entry_t      new_entry, head;
    entry_t      mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic        full, empty;
    state_t      state, next_state;
    logic        upper_done, cur_lower, last_byte, start_lower, vid_ok;
    logic        oe_d, we_d, ce0_d, ce1_d;
    logic [14:0] addr_d;
    logic [7:0]  data_d;

    assign as_s  = as_sync[1];
    assign uds_s = uds_sync[1];
    assign lds_s = lds_sync[1];
    assign rnw_s = rnw_sync[1];

    // Two-flop synchronisers for the asynchronous bus strobes (idle level is high)
    always_ff @(negedge pixClk or posedge reset) begin
        if (reset) begin
            as_sync  <= 2'b11;
            uds_sync <= 2'b11;
            lds_sync <= 2'b11;
            rnw_sync <= 2'b11;
        end else begin
            as_sync  <= {as_sync[0], ncpuAS};
            uds_sync <= {uds_sync[0], ncpuUDS};
            lds_sync <= {lds_sync[0], ncpuLDS};
            rnw_sync <= {rnw_sync[0], cpuRnW};
        end
    end

    assign capture = armed & ~as_s & ~rnw_s & (~uds_s | ~lds_s);

    // Arm between bus cycles so a long strobe produces a single capture
    always_ff @(negedge pixClk or posedge reset) begin
        if (reset)
            armed <= 1'b0;
        else if (capture)
            armed <= 1'b0;
        else if (as_s)
            armed <= 1'b1;
    end

    // Frame buffer decode; a wrapped subtraction also rejects addresses below the base
    always_comb begin
        case (ramSize)
            3'd0:    ram_top = 24'h100000;
            3'd1:    ram_top = 24'h200000;
            3'd2:    ram_top = 24'h280000;
            default: ram_top = 24'h400000;
        endcase
        byte_addr = {cpuAddr, 1'b0};
        main_rel  = byte_addr - (ram_top - MAIN_OFS);
        alt_rel   = byte_addr - (ram_top - ALT_OFS);
        main_hit  = main_rel < BUF_BYTES;
        alt_hit   = alt_rel < BUF_BYTES;
        new_entry.sel  = ~main_hit;
        new_entry.off  = main_hit ? main_rel[14:1] : alt_rel[14:1];
        new_entry.data = cpuData;
        new_entry.ue   = ~uds_s;
        new_entry.le   = ~lds_s;
    end

    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = capture & (main_hit | alt_hit);
    assign push_ok  = push_req & (~full | pop);
    assign head     = mem[rd_ptr];

    // FIFO storage; needs no reset because the pointers qualify every read
    always_ff @(negedge pixClk) begin
        if (push_ok)
            mem[wr_ptr] <= new_entry;
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(negedge pixClk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            fifoOvf <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push_ok)
                count <= count - (PW+1)'(1);
            if (push_req && !push_ok)
                fifoOvf <= 1'b1;
        end
    end

    assign vid_ok    = (vidSeq >= 3'd1) && (vidSeq <= 3'd5);
    assign cur_lower = upper_done | ~head.ue;
    assign last_byte = cur_lower | ~head.le;
    assign pop       = (state == HOLD) & last_byte;

    // Write FSM state register, plus a flag recording that the upper byte is already out
    always_ff @(negedge pixClk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            upper_done <= 1'b0;
        end else begin
            state <= next_state;
            if (state == HOLD)
                upper_done <= ~last_byte;
        end
    end

    // Next-state logic; every new byte re-checks that the write slots are open
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty && vid_ok) next_state = SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  next_state = HOLD;
            HOLD:    next_state = (!last_byte && vid_ok) ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the next state, so the strobes leave a flop cleanly
    always_comb begin
        start_lower = (state == HOLD) ? 1'b1 : cur_lower;
        oe_d        = (next_state != IDLE);
        we_d        = (next_state != STROBE);
        ce0_d       = ~(oe_d & ~head.sel);
        ce1_d       = ~(oe_d & head.sel);
        addr_d      = vramAddr;
        data_d      = vramDataOut;
        if (next_state == SETUP) begin
            addr_d = {head.off, start_lower};
            data_d = start_lower ? head.data[7:0] : head.data[15:8];
        end
    end

    // Registered VRAM outputs; reset releases WE and the chip selects immediately
    always_ff @(negedge pixClk or posedge reset) begin
        if (reset) begin
            vramAddr    <= '0;
            vramDataOut <= '0;
            vramDataOE  <= 1'b0;
            nvramWE     <= 1'b1;
            nvramCE0    <= 1'b1;
            nvramCE1    <= 1'b1;
        end else begin
            vramAddr    <= addr_d;
            vramDataOut <= data_d;
            vramDataOE  <= oe_d;
            nvramWE     <= we_d;
            nvramCE0    <= ce0_d;
            nvramCE1    <= ce1_d;
        end
    end

    assign wrBusy = ~empty | (state != IDLE);

endmodule

// File: tb/tb_vram_write_snoop.sv
// Directed bench for vram_write_snoop. A free-running hCount model drives vidSeq.
// Every VRAM write strobe is recorded as {OE, nCE1, nCE0, addr, data}.
module tb_vram_write_snoop;

    logic        pixClk = 1'b0;
    logic        reset;
    logic [22:0] cpuAddr;
    logic [15:0] cpuData;
    logic        ncpuAS, ncpuUDS, ncpuLDS, cpuRnW;
    logic [2:0]  ramSize;
    logic [2:0]  vidSeq = 3'd0;
    logic [14:0] vramAddr;
    logic [7:0]  vramDataOut;
    logic        vramDataOE, nvramWE, nvramCE0, nvramCE1, wrBusy, fifoOvf;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] wq [$];
    int          bad_window = 0;
    int          act_cnt = 0;
    bit          busy_seen = 1'b0;
    bit          seq_run = 1'b0;
    logic [3:0]  hcnt = 4'd0;

    vram_write_snoop dut (
        .pixClk(pixClk), .reset(reset), .cpuAddr(cpuAddr), .cpuData(cpuData),
        .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS), .ncpuLDS(ncpuLDS), .cpuRnW(cpuRnW),
        .ramSize(ramSize), .vidSeq(vidSeq), .vramAddr(vramAddr),
        .vramDataOut(vramDataOut), .vramDataOE(vramDataOE), .nvramWE(nvramWE),
        .nvramCE0(nvramCE0), .nvramCE1(nvramCE1), .wrBusy(wrBusy), .fifoOvf(fifoOvf)
    );

    // 25 MHz-ish pixel clock
    always #20 pixClk = ~pixClk;

    // Horizontal counter model: vidSeq = hCount[3:1], forced to 0 while stopped
    always @(posedge pixClk) begin
        #1;
        hcnt   = seq_run ? hcnt + 4'd1 : 4'd0;
        vidSeq = hcnt[3:1];
    end

    // One clock: observe outputs on the rising edge, then move off it to drive inputs
    task automatic tick();
        @(posedge pixClk);
        if (!reset) begin
            if (!nvramWE)
                wq.push_back({vramDataOE, nvramCE1, nvramCE0, vramAddr, vramDataOut});
            if ((!nvramCE0 || !nvramCE1) && vidSeq == 3'd0)
                bad_window++;
            if (!nvramWE || !nvramCE0 || !nvramCE1 || vramDataOE)
                act_cnt++;
            if (wrBusy)
                busy_seen = 1'b1;
        end
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One 68000 bus cycle; the strobes stay low for low_clks clocks
    task automatic apply_stimulus(input logic [23:0] addr, input logic [15:0] data,
                                  input logic rnw, input logic uds, input logic lds,
                                  input int low_clks);
        cpuAddr = addr[23:1];
        cpuData = data;
        cpuRnW  = rnw;
        ncpuAS  = 1'b0;
        ncpuUDS = ~uds;
        ncpuLDS = ~lds;
        repeat (low_clks) tick();
        ncpuAS  = 1'b1;
        ncpuUDS = 1'b1;
        ncpuLDS = 1'b1;
        cpuRnW  = 1'b1;
        repeat (4) tick();
    endtask

    // Wait (bounded) for the next recorded write strobe and compare it
    task automatic expect_write(input string tag, input logic [25:0] exp);
        logic [25:0] rec;
        for (int k = 0; k < 300 && wq.size() == 0; k++) tick();
        if (wq.size() > 0) rec = wq.pop_front();
        else rec = 'x;
        check_output(tag, {6'd0, rec}, {6'd0, exp});
    endtask

    initial begin
        int  a0;
        bit  found;

        reset   = 1'b1;
        cpuAddr = '0;
        cpuData = '0;
        ncpuAS  = 1'b1;
        ncpuUDS = 1'b1;
        ncpuLDS = 1'b1;
        cpuRnW  = 1'b1;
        ramSize = 3'd0;
        repeat (3) tick();
        check_output("reset_state",
                     {3'd0, vramAddr, vramDataOut, vramDataOE, nvramWE, nvramCE0, nvramCE1, wrBusy, fifoOvf},
                     {3'd0, 15'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        reset = 1'b0;
        repeat (3) tick();

        $display("[TB] T1 word write to main buffer, 1MB");
        seq_run = 1'b1;
        apply_stimulus(24'h0FA700, 16'hA55A, 1'b0, 1'b1, 1'b1, 5);
        expect_write("t1_upper", {1'b1, 1'b1, 1'b0, 15'h0000, 8'hA5});
        expect_write("t1_lower", {1'b1, 1'b1, 1'b0, 15'h0001, 8'h5A});
        repeat (20) tick();
        check_output("t1_idle", {31'd0, wrBusy}, 32'd0);

        $display("[TB] T2 lower byte write to alt buffer, 4MB");
        ramSize = 3'd3;
        apply_stimulus(24'h3F2701, 16'h00C3, 1'b0, 1'b0, 1'b1, 5);
        expect_write("t2_lower", {1'b1, 1'b0, 1'b1, 15'h0001, 8'hC3});
        repeat (30) tick();
        check_output("t2_single", wq.size(), 32'd0);
        check_output("t2_idle", {31'd0, wrBusy}, 32'd0);

        $display("[TB] T3 misses and read");
        ramSize   = 3'd0;
        a0        = act_cnt;
        busy_seen = 1'b0;
        apply_stimulus(24'h0FA6FE, 16'h1111, 1'b0, 1'b1, 1'b1, 5);
        apply_stimulus(24'h0FFC80, 16'h2222, 1'b0, 1'b1, 1'b1, 5);
        apply_stimulus(24'h0FA700, 16'h3333, 1'b1, 1'b1, 1'b1, 5);
        repeat (20) tick();
        check_output("t3_no_activity", act_cnt - a0, 32'd0);
        check_output("t3_never_busy", {31'd0, busy_seen}, 32'd0);
        check_output("t3_no_writes", wq.size(), 32'd0);

        $display("[TB] T4 overflow with slots blocked, then drain");
        seq_run = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++)
            apply_stimulus(24'h0FA800 + 24'(2 * i), 16'h0100 * 16'(i + 1) + 16'h00E0 + 16'(i),
                           1'b0, 1'b1, 1'b1, 5);
        check_output("t4_ovf", {31'd0, fifoOvf}, 32'd1);
        check_output("t4_busy", {31'd0, wrBusy}, 32'd1);
        check_output("t4_held", wq.size(), 32'd0);
        seq_run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_write($sformatf("t4_upper%0d", i),
                         {1'b1, 1'b1, 1'b0, 15'h0100 + 15'(2 * i), 8'(i + 1)});
            expect_write($sformatf("t4_lower%0d", i),
                         {1'b1, 1'b1, 1'b0, 15'h0101 + 15'(2 * i), 8'hE0 + 8'(i)});
        end
        repeat (20) tick();
        check_output("t4_drained", {31'd0, wrBusy}, 32'd0);
        check_output("t4_dropped", wq.size(), 32'd0);

        $display("[TB] T5 reset during strobe");
        seq_run = 1'b0;
        repeat (2) tick();
        apply_stimulus(24'h0FA700, 16'hBEEF, 1'b0, 1'b1, 1'b1, 5);
        seq_run = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge pixClk);
            found = ~nvramWE;
            if (!found) #1;
        end
        check_output("t5_strobe_seen", {31'd0, found}, 32'd1);
        #5 reset = 1'b1;
        #1;
        check_output("t5_async_release", {28'd0, nvramWE, nvramCE0, nvramCE1, vramDataOE}, {28'd0, 4'b1110});
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_output("t5_not_busy", {31'd0, wrBusy}, 32'd0);
        check_output("t5_ovf_cleared", {31'd0, fifoOvf}, 32'd0);
        wq.delete();
        repeat (30) tick();
        check_output("t5_abandoned", wq.size(), 32'd0);

        $display("[TB] T6 long strobe gives one capture");
        apply_stimulus(24'h0FA900, 16'h1234, 1'b0, 1'b1, 1'b1, 10);
        expect_write("t6_upper", {1'b1, 1'b1, 1'b0, 15'h0200, 8'h12});
        expect_write("t6_lower", {1'b1, 1'b1, 1'b0, 15'h0201, 8'h34});
        repeat (40) tick();
        check_output("t6_one_push", wq.size(), 32'd0);

        check_output("slot0_clear", bad_window, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
